// File: rtl/shift_seq_pkg.sv
// Shared encodings and command payload for the shift-operation sequencer.
package shift_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned AMT_W  = 3;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_SHL  = 2'b10,
    OP_SHR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic SEL_LEFT   = 1'b0;
  localparam logic SEL_RIGHT  = 1'b1;
  localparam logic SEL2_DIN   = 1'b0;
  localparam logic SEL2_SHIFT = 1'b1;

  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [AMT_W-1:0]  amt;
    logic [DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/shift_op_sequencer_pass_counter.sv
// Remaining-pass counter: loads on accept, decrements once per pass, flags the final pass.
module pass_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = CNT_W'(cnt_q - CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_op_sequencer.sv
// Command sequencer for the 8x8 shift register file: one command per handshake,
// one read/shift/write-back pass per EXEC cycle, done pulse on completion.
module shift_op_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [AMT_W-1:0]  cmd_amt,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [ADDR_W-1:0] obs_addr,
  output logic              busy,
  output logic              done,
  output logic              wr,
  output logic              sel,
  output logic              sel2,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [AMT_W-1:0]  ctrl,
  output logic [DATA_W-1:0] d_in
);

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic             first_q, first_d;
  logic             cnt_load, cnt_dec, cnt_last;
  logic [CNT_W-1:0] cnt_load_val;

  // LOAD is always a single pass; a zero count still means one pass.
  assign cnt_load_val = ((cmd_op == OP_LOAD) || (cmd_count == '0)) ? CNT_W'(1) : cmd_count;

  pass_counter #(.CNT_W(CNT_W)) u_pass_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .last_c     (cnt_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      first_q <= first_d;
    end
  end

  // Next state and Moore-style control decode from registered state/captured fields.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    first_d   = first_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    wr        = 1'b0;
    sel       = SEL_LEFT;
    sel2      = SEL2_DIN;
    ctrl      = '0;
    wr_addr   = '0;
    d_in      = '0;
    rd_addr   = cmd_q.dst;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        rd_addr   = obs_addr;
        if (cmd_valid) begin
          cnt_load = 1'b1;
          first_d  = 1'b1;
          cmd_d    = '{op: op_e'(cmd_op), src: cmd_src, dst: cmd_dst,
                       amt: cmd_amt, data: cmd_data};
          state_d  = (op_e'(cmd_op) == OP_NOP) ? ST_DONE : ST_EXEC;
        end
      end
      ST_EXEC: begin
        busy    = 1'b1;
        wr      = 1'b1;
        wr_addr = cmd_q.dst;
        cnt_dec = 1'b1;
        first_d = 1'b0;
        if (cmd_q.op == OP_LOAD) begin
          sel2 = SEL2_DIN;
          d_in = cmd_q.data;
        end else begin
          sel2    = SEL2_SHIFT;
          sel     = cmd_q.op[0] ? SEL_RIGHT : SEL_LEFT;
          ctrl    = cmd_q.amt;
          // Later passes re-shift the partial result already in dst.
          rd_addr = first_q ? cmd_q.src : cmd_q.dst;
        end
        if (cnt_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Directed bench: sequencer driving a behavioural shiftoperations register file.
module tb_shift_op_sequencer;
  import shift_seq_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [2:0]       cmd_src = 3'd0;
  logic [2:0]       cmd_dst = 3'd0;
  logic [2:0]       cmd_amt = 3'd0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [7:0]       cmd_data = 8'h00;
  logic [2:0]       obs_addr = 3'd0;
  logic             busy, done, wr, sel, sel2;
  logic [2:0]       rd_addr, wr_addr, ctrl;
  logic [7:0]       d_in;

  int checks = 0;
  int errors = 0;

  shift_op_sequencer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_amt   (cmd_amt),
    .cmd_count (cmd_count),
    .cmd_data  (cmd_data),
    .obs_addr  (obs_addr),
    .busy      (busy),
    .done      (done),
    .wr        (wr),
    .sel       (sel),
    .sel2      (sel2),
    .rd_addr   (rd_addr),
    .wr_addr   (wr_addr),
    .ctrl      (ctrl),
    .d_in      (d_in)
  );

  // Behavioural shiftoperations: combinational read, synchronous write, zero-fill shifts.
  logic [7:0] rf [8] = '{default: 8'h00};
  logic [7:0] rd_data, shift_out;
  assign rd_data   = rf[rd_addr];
  assign shift_out = sel ? (rd_data >> ctrl) : (rd_data << ctrl);
  always @(posedge clk) begin
    if (wr) rf[wr_addr] <= sel2 ? shift_out : d_in;
  end

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                       input logic [2:0] amt, input logic [CNT_W-1:0] cnt, input logic [7:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_amt   = amt;
    cmd_count = cnt;
    cmd_data  = data;
  endtask

  task automatic test_reset();
    obs_addr = 3'd6;
    #2;
    checks++;
    if ({wr, done, busy, sel, sel2, ctrl, wr_addr, d_in, cmd_ready, rd_addr} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 1'b1, 3'd6}) begin
      errors++;
      $display("FAIL reset_init got %h exp %h",
               {wr, done, busy, sel, sel2, ctrl, wr_addr, d_in, cmd_ready, rd_addr},
               {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 1'b1, 3'd6});
    end
    tick();
    reset = 1'b1;
    tick();
    offer(OP_SHL, 3'd1, 3'd7, 3'd3, 4'd5, 8'h11);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({wr, busy, sel2, ctrl} !== {1'b1, 1'b1, 1'b1, 3'd3}) begin
      errors++;
      $display("FAIL reset_pre_exec got %h exp %h", {wr, busy, sel2, ctrl}, {1'b1, 1'b1, 1'b1, 3'd3});
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({wr, done, busy, sel, sel2, ctrl, wr_addr, d_in, cmd_ready, rd_addr} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 1'b1, 3'd6}) begin
      errors++;
      $display("FAIL reset_midrun got %h exp %h",
               {wr, done, busy, sel, sel2, ctrl, wr_addr, d_in, cmd_ready, rd_addr},
               {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 1'b1, 3'd6});
    end
    obs_addr = 3'd2;
    #1;
    checks++;
    if (rd_addr !== 3'd2) begin
      errors++;
      $display("FAIL reset_obs_track got %h exp %h", rd_addr, 3'd2);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load();
    offer(OP_LOAD, 3'd0, 3'd3, 3'd0, 4'd9, 8'hA5);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({wr, wr_addr, sel2, d_in, busy, cmd_ready} !== {1'b1, 3'd3, 1'b0, 8'hA5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL load_exec got %h exp %h", {wr, wr_addr, sel2, d_in, busy, cmd_ready},
               {1'b1, 3'd3, 1'b0, 8'hA5, 1'b1, 1'b0});
    end
    tick();
    checks++;
    if ({done, wr, busy, cmd_ready} !== 4'b1010) begin
      errors++;
      $display("FAIL load_done got %b exp %b", {done, wr, busy, cmd_ready}, 4'b1010);
    end
    tick();
    checks++;
    if ({done, busy, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL load_idle got %b exp %b", {done, busy, cmd_ready}, 3'b001);
    end
    obs_addr = 3'd3;
    #1;
    checks++;
    if (rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL load_r3 got %h exp %h", rd_data, 8'hA5);
    end
  endtask

  task automatic test_shl();
    logic [2:0] exp_rd [3] = '{3'd3, 3'd5, 3'd5};
    offer(OP_SHL, 3'd3, 3'd5, 3'd1, 4'd3, 8'h00);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({wr, wr_addr, rd_addr, sel, sel2, ctrl, done} !==
          {1'b1, 3'd5, exp_rd[i], 1'b0, 1'b1, 3'd1, 1'b0}) begin
        errors++;
        $display("FAIL shl_pass%0d got %h exp %h", i, {wr, wr_addr, rd_addr, sel, sel2, ctrl, done},
                 {1'b1, 3'd5, exp_rd[i], 1'b0, 1'b1, 3'd1, 1'b0});
      end
      tick();
    end
    checks++;
    if ({done, wr} !== 2'b10) begin
      errors++;
      $display("FAIL shl_done got %b exp %b", {done, wr}, 2'b10);
    end
    tick();
    obs_addr = 3'd5;
    #1;
    checks++;
    if (rd_data !== 8'h28) begin
      errors++;
      $display("FAIL shl_r5 got %h exp %h", rd_data, 8'h28);
    end
  endtask

  task automatic test_shr();
    offer(OP_SHR, 3'd5, 3'd5, 3'd2, 4'd2, 8'h00);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({wr, sel, sel2, ctrl, rd_addr} !== {1'b1, 1'b1, 1'b1, 3'd2, 3'd5}) begin
        errors++;
        $display("FAIL shr_pass%0d got %h exp %h", i, {wr, sel, sel2, ctrl, rd_addr},
                 {1'b1, 1'b1, 1'b1, 3'd2, 3'd5});
      end
      tick();
    end
    checks++;
    if ({done, wr} !== 2'b10) begin
      errors++;
      $display("FAIL shr_done got %b exp %b", {done, wr}, 2'b10);
    end
    tick();
    obs_addr = 3'd5;
    #1;
    checks++;
    if (rd_data !== 8'h02) begin
      errors++;
      $display("FAIL shr_r5 got %h exp %h", rd_data, 8'h02);
    end
    // Zero count behaves as a single pass.
    offer(OP_SHR, 3'd3, 3'd6, 3'd4, 4'd0, 8'h00);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({wr, rd_addr, wr_addr} !== {1'b1, 3'd3, 3'd6}) begin
      errors++;
      $display("FAIL shr_cnt0_exec got %h exp %h", {wr, rd_addr, wr_addr}, {1'b1, 3'd3, 3'd6});
    end
    tick();
    checks++;
    if ({done, wr} !== 2'b10) begin
      errors++;
      $display("FAIL shr_cnt0_done got %b exp %b", {done, wr}, 2'b10);
    end
    tick();
    obs_addr = 3'd6;
    #1;
    checks++;
    if (rd_data !== 8'h0A) begin
      errors++;
      $display("FAIL shr_cnt0_r6 got %h exp %h", rd_data, 8'h0A);
    end
  endtask

  task automatic test_reset_abort();
    offer(OP_SHL, 3'd3, 3'd5, 3'd1, 4'd3, 8'h00);
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if ({wr, rd_addr} !== {1'b1, 3'd5}) begin
      errors++;
      $display("FAIL abort_pass2 got %h exp %h", {wr, rd_addr}, {1'b1, 3'd5});
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({wr, busy, done, cmd_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL abort_async got %b exp %b", {wr, busy, done, cmd_ready}, 4'b0001);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({done, busy, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL abort_nodone got %b exp %b", {done, busy, cmd_ready}, 3'b001);
    end
    obs_addr = 3'd5;
    #1;
    checks++;
    if (rd_data !== 8'h4A) begin
      errors++;
      $display("FAIL abort_r5 got %h exp %h", rd_data, 8'h4A);
    end
    offer(OP_LOAD, 3'd0, 3'd1, 3'd0, 4'd0, 8'h3C);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({wr, wr_addr, d_in} !== {1'b1, 3'd1, 8'h3C}) begin
      errors++;
      $display("FAIL abort_next_exec got %h exp %h", {wr, wr_addr, d_in}, {1'b1, 3'd1, 8'h3C});
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL abort_next_done got %b exp %b", done, 1'b1);
    end
    tick();
    obs_addr = 3'd1;
    #1;
    checks++;
    if (rd_data !== 8'h3C) begin
      errors++;
      $display("FAIL abort_next_r1 got %h exp %h", rd_data, 8'h3C);
    end
  endtask

  task automatic test_back_to_back();
    offer(OP_NOP, 3'd0, 3'd0, 3'd0, 4'd0, 8'h00);
    tick();
    offer(OP_LOAD, 3'd0, 3'd2, 3'd0, 4'd0, 8'h77);
    checks++;
    if ({done, wr, busy, cmd_ready} !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_nop_done got %b exp %b", {done, wr, busy, cmd_ready}, 4'b1010);
    end
    tick();
    checks++;
    if ({cmd_ready, done, wr, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_gap got %b exp %b", {cmd_ready, done, wr, busy}, 4'b1000);
    end
    tick();
    offer(OP_SHR, 3'd7, 3'd4, 3'd3, 4'd7, 8'hFF);
    #1;
    checks++;
    if ({wr, wr_addr, sel2, d_in} !== {1'b1, 3'd2, 1'b0, 8'h77}) begin
      errors++;
      $display("FAIL b2b_load_exec got %h exp %h", {wr, wr_addr, sel2, d_in}, {1'b1, 3'd2, 1'b0, 8'h77});
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({done, wr, cmd_ready} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_load_done got %b exp %b", {done, wr, cmd_ready}, 3'b100);
    end
    tick();
    obs_addr = 3'd2;
    #1;
    checks++;
    if (rd_data !== 8'h77) begin
      errors++;
      $display("FAIL b2b_r2 got %h exp %h", rd_data, 8'h77);
    end
    obs_addr = 3'd4;
    #1;
    checks++;
    if ((rd_data !== 8'h00) || (busy !== 1'b0)) begin
      errors++;
      $display("FAIL b2b_r4_untouched got %h/%b exp %h/%b", rd_data, busy, 8'h00, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shl();
    test_shr();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
